// File: rtl/fft_frame_collect.sv
// Collects N streamed samples into a slot buffer and publishes them as one
// packed frame on data_bus, then freezes the bus for a serial readout window.
module fft_frame_collect #(
    parameter int N           = 32,
    parameter int MSB         = 16,
    parameter int HOLD_CYCLES = 2048
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    input  logic [MSB-1:0]   in_data,
    input  logic             in_last,
    output logic             in_ready,
    output logic [N*MSB-1:0] data_bus,
    output logic             start_spi,
    output logic             frame_err,
    output logic [7:0]       frame_cnt
);

    localparam int IW = $clog2(N);
    localparam int HW = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;

    typedef enum logic [1:0] {FILL, PUBLISH, HOLD} state_t;

    state_t         state, state_nxt;
    logic [IW-1:0]  wr_idx, wr_idx_nxt;
    logic [HW-1:0]  hold_cnt;
    logic           pending, pending_nxt;
    logic           err_set;
    logic           xfer, at_end, frame_done;
    logic [MSB-1:0] slots [N];

    // Ready depends only on state and pending, never on in_valid.
    assign in_ready   = (state == FILL) || ((state == HOLD) && !pending);
    assign xfer       = in_valid && in_ready;
    assign at_end     = (wr_idx == IW'(N - 1));
    assign frame_done = xfer && at_end && in_last;

    always_comb begin
        // NOTE: every output of this block gets a default first so no path
        // leaves it unassigned, which would otherwise infer a latch.
        state_nxt   = state;
        wr_idx_nxt  = wr_idx;
        pending_nxt = pending;
        err_set     = 1'b0;

        if (xfer) begin
            wr_idx_nxt = (at_end || in_last) ? '0 : wr_idx + 1'b1;
            err_set    = (at_end != in_last);
        end

        case (state)
            FILL:    if (frame_done) state_nxt = PUBLISH;
            PUBLISH: state_nxt = HOLD;
            HOLD: begin
                if (frame_done) pending_nxt = 1'b1;
                if (hold_cnt == '0) begin
                    state_nxt   = (pending || frame_done) ? PUBLISH : FILL;
                    pending_nxt = 1'b0;
                end
            end
            default: state_nxt = FILL;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values of the others, independent of block order.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= FILL;
            wr_idx    <= '0;
            hold_cnt  <= '0;
            pending   <= 1'b0;
            data_bus  <= '0;
            frame_cnt <= '0;
            frame_err <= 1'b0;
            start_spi <= 1'b0;
        end else begin
            state     <= state_nxt;
            wr_idx    <= wr_idx_nxt;
            pending   <= pending_nxt;
            start_spi <= (state == PUBLISH);
            if (err_set) frame_err <= 1'b1;

            if (state == PUBLISH) begin
                for (int k = 0; k < N; k++) data_bus[k*MSB +: MSB] <= slots[k];
                frame_cnt <= frame_cnt + 8'd1;
                hold_cnt  <= HW'(HOLD_CYCLES - 1);
            end else if ((state == HOLD) && (hold_cnt != '0)) begin
                hold_cnt <= hold_cnt - 1'b1;
            end
        end
    end

    // NOTE: the slot buffer is deliberately not reset; every slot is written
    // before a frame can publish, so clearing it would only cost logic.
    always_ff @(posedge clk) begin
        if (xfer) slots[wr_idx] <= in_data;
    end

endmodule
